game_axi_lite_regs: RTL and testbench

GAME_AXI_LITE_REGS -- requirements
Module: game_axi_lite_regs

---
 rtl/game_axi_lite_regs.sv | 160 ++++++++++++++++
 tb/tb_game_axi_lite_regs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_axi_lite_regs.sv
// AXI4-Lite slave exposing four 32-bit read/write registers to game logic.
// Write address and data are latched independently; the write commits on the
// edge where the second of the two arrives. Reads return data one cycle after
// the AR handshake and run fully in parallel with writes.
module game_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  // Goes high on the first clock after reset release so READYs stay low in reset.
  logic                          ready_en_reg;
  logic                          aw_held_reg;
  logic [1:0]                    aw_addr_reg;
  logic                          w_held_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_W-1:0]             w_strb_reg;
  logic                          bvalid_reg;
  logic                          rvalid_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [3:0]                    wr_pulse_reg;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          commit;
  logic [1:0]                    wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_file [4];

  // Protection bits and byte-offset bits carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = ready_en_reg & ~aw_held_reg & ~bvalid_reg;
  assign S_AXI_WREADY  = ready_en_reg & ~w_held_reg & ~bvalid_reg;
  assign S_AXI_ARREADY = ready_en_reg & ~rvalid_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign wr_pulse_o    = wr_pulse_reg;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Commit as soon as both halves are present, whether held or arriving now.
  assign commit  = (aw_hs | aw_held_reg) & (w_hs | w_held_reg);
  assign wr_addr = aw_held_reg ? aw_addr_reg : S_AXI_AWADDR[3:2];
  assign wr_data = w_held_reg ? w_data_reg : S_AXI_WDATA;
  assign wr_strb = w_held_reg ? w_strb_reg : S_AXI_WSTRB;

  // Write channel: AW/W latching, commit, B response and the commit pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_reg <= 1'b0;
      aw_held_reg  <= 1'b0;
      aw_addr_reg  <= '0;
      w_held_reg   <= 1'b0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      wr_pulse_reg <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      wr_pulse_reg <= commit ? (4'd1 << wr_addr) : 4'd0;
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_addr_reg <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= S_AXI_WDATA;
          w_strb_reg <= S_AXI_WSTRB;
        end
        if (bvalid_reg && S_AXI_BREADY) begin
          bvalid_reg <= 1'b0;
        end
      end
    end
  end

  // Read channel: sample the register file on AR handshake, hold until RREADY.
  // The register file updates with non-blocking assignments, so a same-edge
  // commit is not visible here and the old value is returned.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= reg_file[S_AXI_ARADDR[3:2]];
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
      logic [C_S_AXI_DATA_WIDTH-1:0] value_reg;

      // Byte-lane update of this register on a commit addressed to it.
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          value_reg <= '0;
        end else if (commit && (wr_addr == 2'(gi))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              value_reg[8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end

      assign reg_file[gi] = value_reg;
    end
  endgenerate

  assign reg0_o = reg_file[0];
  assign reg1_o = reg_file[1];
  assign reg2_o = reg_file[2];
  assign reg3_o = reg_file[3];

endmodule

// File: tb/tb_game_axi_lite_regs.sv
// Directed bench for game_axi_lite_regs: drives on the falling edge, samples
// on the falling edge, compares against hand-computed values.
module tb_game_axi_lite_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic [3:0]  wr_pulse_o;

  int          num_checks = 0;
  int          num_errors = 0;
  logic [3:0]  last_pulse;
  logic [31:0] rd;

  always #5 ACLK = ~ACLK;

  game_axi_lite_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .wr_pulse_o(wr_pulse_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Full write with AW and W presented together; leaves at a falling edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int   n;
    logic aw_fire, w_fire;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    n = 0;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
      aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID & S_AXI_WREADY;
      @(negedge ACLK);
      n++;
      if (aw_fire) S_AXI_AWVALID = 1'b0;
      if (w_fire)  S_AXI_WVALID  = 1'b0;
    end
    check("write_handshake_in_time", 32'(n < 20), 32'd1);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    last_pulse = wr_pulse_o;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("bvalid_in_time", 32'(n < 20), 32'd1);
    check("bresp", 32'(S_AXI_BRESP), 32'd0);
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    $display("write addr=0x%h data=0x%08h strb=%b pulse=%b", addr, data, strb, last_pulse);
  endtask

  // Single read; checks 1-cycle latency and RRESP.
  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("arready_in_time", 32'(n < 20), 32'd1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid_latency", 32'(S_AXI_RVALID), 32'd1);
    check("rresp", 32'(S_AXI_RRESP), 32'd0);
    data = S_AXI_RDATA;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    $display("read  addr=0x%h data=0x%08h", addr, data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_pulse", 32'(wr_pulse_o), 32'd0);
    check("rst_regs", reg0_o | reg1_o | reg2_o | reg3_o, 32'd0);
    ARESETN = 1'b1;
    #1;
    check("ready_before_edge", 32'(S_AXI_AWREADY), 32'd0);
    @(negedge ACLK);
    check("awready_after_rst", 32'(S_AXI_AWREADY), 32'd1);
    check("wready_after_rst", 32'(S_AXI_WREADY), 32'd1);
    check("arready_after_rst", 32'(S_AXI_ARREADY), 32'd1);

    // Write all four registers then read back
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF);
      check("basic_pulse", 32'(last_pulse), 32'(4'd1 << i));
    end
    check("reg0_o", reg0_o, 32'h1);
    check("reg3_o", reg3_o, 32'h4);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("basic_read", rd, 32'(i + 1));
    end
    axi_read(4'h7, rd);
    check("ignore_low_addr_bits", rd, 32'h2);

    // W three cycles ahead of AW at 0x8
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    check("w_first_wready", 32'(S_AXI_WREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    repeat (2) begin
      check("w_held_wready", 32'(S_AXI_WREADY), 32'd0);
      check("w_held_no_bvalid", 32'(S_AXI_BVALID), 32'd0);
      check("w_held_reg2", reg2_o, 32'h3);
      @(negedge ACLK);
    end
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    check("aw_late_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check("w_first_reg2", reg2_o, 32'hDEADBEEF);
    check("w_first_pulse", 32'(wr_pulse_o), 32'h4);
    check("w_first_bvalid", 32'(S_AXI_BVALID), 32'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("w_first_pulse_gone", 32'(wr_pulse_o), 32'd0);
    check("w_first_bvalid_gone", 32'(S_AXI_BVALID), 32'd0);
    $display("write addr=0x8 data=0xdeadbeef W-before-AW");

    // Byte-lane write
    axi_write(4'h4, 32'h11223344, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101);
    check("strb_reg1_o", reg1_o, 32'h11BB33DD);
    axi_read(4'h4, rd);
    check("strb_read", rd, 32'h11BB33DD);

    // Zero strobe: no data change, still a pulse and response
    axi_write(4'hC, 32'hFFFFFFFF, 4'b0000);
    check("zero_strb_pulse", 32'(last_pulse), 32'h8);
    check("zero_strb_reg3", reg3_o, 32'h4);

    // BREADY held low: no new AW/W accepted until B handshake
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h88;
    for (int k = 0; k < 5; k++) begin
      check("bhold_bvalid", 32'(S_AXI_BVALID), 32'd1);
      check("bhold_awready", 32'(S_AXI_AWREADY), 32'd0);
      check("bhold_wready", 32'(S_AXI_WREADY), 32'd0);
      @(negedge ACLK);
    end
    check("bhold_reg3", reg3_o, 32'h77);
    check("bhold_reg2_untouched", reg2_o, 32'hDEADBEEF);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("bhold_awready_after_b", 32'(S_AXI_AWREADY), 32'd1);
    check("bhold_bvalid_after_b", 32'(S_AXI_BVALID), 32'd0);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("second_write_reg2", reg2_o, 32'h88);
    check("second_write_bvalid", 32'(S_AXI_BVALID), 32'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    $display("write addr=0xc data=0x77 then addr=0x8 data=0x88 with stalled B");

    // Same-edge read and write commit to REG1
    axi_write(4'h4, 32'h5, 4'hF);
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("collide_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("collide_rdata_old", S_AXI_RDATA, 32'h5);
    check("collide_reg1_new", reg1_o, 32'h9);
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    $display("collide read/write addr=0x4 old=0x5 new=0x9");
    axi_read(4'h4, rd);
    check("collide_read_new", rd, 32'h9);

    // Reset during an outstanding read and a latched AW
    axi_write(4'h0, 32'hCAFE0000, 4'hF);
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("midrst_rvalid_before", 32'(S_AXI_RVALID), 32'd1);
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check("midrst_aw_latched", 32'(S_AXI_AWREADY), 32'd0);
    #2 ARESETN = 1'b0;
    #1;
    check("midrst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("midrst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("midrst_rdata", S_AXI_RDATA, 32'd0);
    check("midrst_regs", reg0_o | reg1_o | reg2_o | reg3_o, 32'd0);
    check("midrst_arready", 32'(S_AXI_ARREADY), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("midrst_aw_dropped", 32'(S_AXI_AWREADY), 32'd1);
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    check("midrst_no_commit_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("midrst_no_commit_reg0", reg0_o, 32'd0);
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check("post_rst_write_reg0", reg0_o, 32'h55);
    check("post_rst_write_pulse", 32'(wr_pulse_o), 32'h1);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    $display("reset mid-transaction, then write addr=0x0 data=0x55");

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
